multi_channel_serial_therm_accumulator: RTL and testbench



---
 rtl/multi_channel_serial_therm_accumulator_if.sv | 34 +++
 rtl/multi_channel_serial_therm_accumulator.sv | 152 +++++++++++++++
 tb/tb_multi_channel_serial_therm_accumulator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_channel_serial_therm_accumulator_if.sv
// Handshake/bus bundle for multi_channel_serial_therm_accumulator.
// Optional feature macro: SIGNED_OUTPUT_EN (adds one bit to each per-channel sum field).
interface multi_channel_serial_therm_accumulator_if #(
  parameter int unsigned SERIAL_INPUT_LENGTH = 6,
  parameter int unsigned NUM_CHANNELS        = 4
);
  localparam int unsigned CW = $clog2(SERIAL_INPUT_LENGTH + 1);
`ifdef SIGNED_OUTPUT_EN
  localparam int unsigned OW = CW + 1;
`else
  localparam int unsigned OW = CW;
`endif

  logic                         start;
  logic                         in_valid;
  logic [NUM_CHANNELS-1:0]      serial_in;
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [NUM_CHANNELS*OW-1:0]   sum_out;
  logic [NUM_CHANNELS-1:0]      therm_err;

  // Producer/consumer side: drives frames in, takes results out
  modport master (
    output start, in_valid, serial_in, out_ready,
    input  busy, out_valid, sum_out, therm_err
  );

  // Accumulator side
  modport slave (
    input  start, in_valid, serial_in, out_ready,
    output busy, out_valid, sum_out, therm_err
  );
endinterface

// File: rtl/multi_channel_serial_therm_accumulator.sv
// Multi-channel bit-serial thermometer-code accumulator.
// Counts the ones in each SERIAL_INPUT_LENGTH-bit frame on NUM_CHANNELS lock-step
// serial streams, flags thermometer-order violations, and hands the per-channel
// results out under a valid/ready handshake.
// Optional feature macro: SIGNED_OUTPUT_EN -- when defined, each result is the
// bipolar mapping 2*count - SERIAL_INPUT_LENGTH in two's complement (one extra bit);
// when undefined, each result is the unsigned popcount.
module multi_channel_serial_therm_accumulator #(
  parameter int unsigned SERIAL_INPUT_LENGTH = 6,
  parameter int unsigned NUM_CHANNELS        = 4
) (
  input  logic clk,
  input  logic rst_n,
  multi_channel_serial_therm_accumulator_if.slave bus
);

  localparam int unsigned CW = $clog2(SERIAL_INPUT_LENGTH + 1);
`ifdef SIGNED_OUTPUT_EN
  localparam int unsigned OW = CW + 1;
`else
  localparam int unsigned OW = CW;
`endif

  // Reject configurations the datapath is not built for
  if (SERIAL_INPUT_LENGTH < 2) begin : g_bad_len
    $error("SERIAL_INPUT_LENGTH must be >= 2");
  end
  if (NUM_CHANNELS < 1) begin : g_bad_ch
    $error("NUM_CHANNELS must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                              state_q, state_d;
  logic [NUM_CHANNELS-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]                       bit_cnt_q, bit_cnt_d;
  logic [NUM_CHANNELS-1:0]             seen_zero_q, seen_zero_d;
  logic [NUM_CHANNELS-1:0]             err_q, err_d;
  logic                                busy_q, busy_d;
  logic                                out_valid_q, out_valid_d;
  logic [NUM_CHANNELS*OW-1:0]          sum_q, sum_d;
  logic [NUM_CHANNELS-1:0]             therm_err_q, therm_err_d;
  logic                                frame_start;
  logic                                accum_sample;
  logic                                last_bit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-channel counters, ordering flags and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      seen_zero_q <= '0;
      err_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      therm_err_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      seen_zero_q <= seen_zero_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      therm_err_q <= therm_err_d;
    end
  end

  // Next state, datapath update and output capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    seen_zero_d = seen_zero_q;
    err_d       = err_q;
    sum_d       = sum_q;
    therm_err_d = therm_err_q;

    // A frame may open from IDLE, or from DONE in the same cycle the result is taken
    frame_start  = bus.in_valid && bus.start &&
                   ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
    accum_sample = bus.in_valid && (state_q == ACCUM);
    last_bit     = accum_sample && (bit_cnt_q == CW'(SERIAL_INPUT_LENGTH - 1));

    case (state_q)
      IDLE: begin
        if (frame_start) state_d = ACCUM;
      end
      ACCUM: begin
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = frame_start ? ACCUM : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_start) begin
      bit_cnt_d = CW'(1);
    end else if (accum_sample) begin
      bit_cnt_d = bit_cnt_q + CW'(1);
    end

    // Bit 0 reloads each channel; later bits accumulate and check 1s-then-0s order
    for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
      if (frame_start) begin
        cnt_d[k]       = CW'(bus.serial_in[k]);
        seen_zero_d[k] = ~bus.serial_in[k];
        err_d[k]       = 1'b0;
      end else if (accum_sample) begin
        cnt_d[k]       = cnt_q[k] + CW'(bus.serial_in[k]);
        err_d[k]       = err_q[k] | (seen_zero_q[k] & bus.serial_in[k]);
        seen_zero_d[k] = seen_zero_q[k] | ~bus.serial_in[k];
      end
    end

    // Results change only on the edge that enters DONE
    if (last_bit) begin
      for (int k = 0; k < int'(NUM_CHANNELS); k++) begin
`ifdef SIGNED_OUTPUT_EN
        sum_d[k*OW +: OW] = OW'({cnt_d[k], 1'b0}) - OW'(SERIAL_INPUT_LENGTH);
`else
        sum_d[k*OW +: OW] = cnt_d[k];
`endif
      end
      therm_err_d = err_d;
    end

    busy_d      = (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.therm_err = therm_err_q;

endmodule

// File: tb/tb_multi_channel_serial_therm_accumulator.sv
// Directed bench for multi_channel_serial_therm_accumulator (L=6, N=4).
// Streams are written MSB-first: the leftmost bit is the first bit on the wire.
`timescale 1ns/1ps
module tb_multi_channel_serial_therm_accumulator;

  localparam int unsigned L  = 6;
  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;
`ifdef SIGNED_OUTPUT_EN
  localparam int unsigned OW = CW + 1;
`else
  localparam int unsigned OW = CW;
`endif

  logic clk;
  logic rst_n;

  multi_channel_serial_therm_accumulator_if #(
    .SERIAL_INPUT_LENGTH(L),
    .NUM_CHANNELS(N)
  ) bus ();

  multi_channel_serial_therm_accumulator #(
    .SERIAL_INPUT_LENGTH(L),
    .NUM_CHANNELS(N)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pack four per-channel popcounts into the expected sum_out word
  function automatic logic [N*OW-1:0] exp_sum(input int c0, input int c1, input int c2, input int c3);
    int c [4];
    logic [N*OW-1:0] r;
    c = '{c0, c1, c2, c3};
    r = '0;
    for (int k = 0; k < 4; k++) begin
`ifdef SIGNED_OUTPUT_EN
      r[k*OW +: OW] = OW'(2 * c[k] - int'(L));
`else
      r[k*OW +: OW] = OW'(c[k]);
`endif
    end
    return r;
  endfunction

  // Drive one frame starting now; gap cycles carry inverted bits that must be ignored.
  // A stray start on cycle 3 must also be ignored while the frame is in progress.
  task automatic drive_frame(input string tag, input logic [N-1:0][L-1:0] s,
                             input logic [15:0] gaps, input int exp_cycles,
                             input logic [N*OW-1:0] exp_s, input logic [N-1:0] exp_e);
    int c;
    int j;
    c = 0;
    j = 0;
    while (j < int'(L) && c < 16) begin
      bus.in_valid  = ~gaps[c];
      bus.start     = (c == 0) || (c == 3);
      bus.out_ready = (c == 0);
      for (int k = 0; k < int'(N); k++)
        bus.serial_in[k] = bus.in_valid ? s[k][L-1-j] : ~s[k][L-1-j];
      if (c > 0) begin
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check_eq({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      end else begin
        check_eq({tag, "_busy0"}, 32'(bus.busy), 32'd0);
      end
      if (bus.in_valid) j++;
      tick();
      c++;
    end
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.serial_in = '0;
    check_eq({tag, "_latency"}, 32'(c), 32'(exp_cycles));
    check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_sum"}, 32'(bus.sum_out), 32'(exp_s));
    check_eq({tag, "_err"}, 32'(bus.therm_err), 32'(exp_e));
  endtask

  // Complete the handshake with no new start; result must stay on sum_out
  task automatic accept(input string tag, input logic [N*OW-1:0] exp_s);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "_sum_kept"}, 32'(bus.sum_out), 32'(exp_s));
  endtask

  logic [N-1:0][L-1:0] s_a, s_t, s_s, s_r;
  logic [N*OW-1:0]     sum_a, sum_t, sum_s, sum_r;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.serial_in = '0;

    s_a[0] = 6'b111000; s_a[1] = 6'b000000; s_a[2] = 6'b111111; s_a[3] = 6'b110000;
    s_t[0] = 6'b111000; s_t[1] = 6'b101100; s_t[2] = 6'b111111; s_t[3] = 6'b110000;
    s_s[0] = 6'b000000; s_s[1] = 6'b111000; s_s[2] = 6'b111111; s_s[3] = 6'b100000;
    s_r[0] = 6'b100000; s_r[1] = 6'b000000; s_r[2] = 6'b110000; s_r[3] = 6'b000000;
    sum_a = exp_sum(3, 0, 6, 2);
    sum_t = exp_sum(3, 3, 6, 2);
`ifdef SIGNED_OUTPUT_EN
    sum_s = 16'hC60A;
`else
    sum_s = exp_sum(0, 3, 6, 1);
`endif
    sum_r = exp_sum(1, 0, 2, 0);

    tick();
    tick();
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_sum", 32'(bus.sum_out), 32'd0);
    check_eq("rst_err", 32'(bus.therm_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // start without in_valid must not open a frame
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("start_no_valid_busy", 32'(bus.busy), 32'd0);

    drive_frame("nostall", s_a, 16'h0000, 6, sum_a, 4'b0000);
    accept("nostall", sum_a);

    drive_frame("stall", s_a, 16'h0014, 8, sum_a, 4'b0000);

    // Backpressure: result held, starts during DONE ignored
    for (int i = 0; i < 3; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      bus.in_valid  = 1'b1;
      bus.serial_in = '1;
      tick();
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_busy", 32'(bus.busy), 32'd0);
      check_eq("bp_sum", 32'(bus.sum_out), 32'(sum_a));
    end

    // Zero-bubble restart from DONE with a thermometer violation on channel 1
    drive_frame("therm", s_t, 16'h0000, 6, sum_t, 4'b0010);
    drive_frame("bipolar", s_s, 16'h0000, 6, sum_s, 4'b0000);

    // Abort a frame with reset on its cycle 3 while sum_out still holds a result
    for (int c = 0; c < 3; c++) begin
      bus.start     = (c == 0);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      bus.serial_in = '1;
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_valid", 32'(bus.out_valid), 32'd0);
    check_eq("abort_sum", 32'(bus.sum_out), 32'd0);
    check_eq("abort_err", 32'(bus.therm_err), 32'd0);
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.serial_in = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_idle", 32'(bus.busy), 32'd0);
    drive_frame("after_rst", s_r, 16'h0000, 6, sum_r, 4'b0000);
    accept("after_rst", sum_r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
